// File: rtl/antares_mem_pkg.sv
// Shared definitions for the Antares MEM-stage data port: FSM state encoding,
// byte-enable constants, access-size encoding and the lane-select helper.
package antares_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_BYTE = 2'd2
  } access_size_t;

  // Bit 3 of a select enables data bits [31:24] (big-endian byte 0)
  localparam logic [3:0] SEL_WORD    = 4'b1111;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_BYTE0   = 4'b1000;

  function automatic logic [3:0] lane_select(access_size_t size, logic [1:0] offset);
    case (size)
      SIZE_BYTE: lane_select = SEL_BYTE0 >> offset;
      SIZE_HALF: lane_select = offset[1] ? SEL_HALF_LO : SEL_HALF_HI;
      default:   lane_select = SEL_WORD;
    endcase
  endfunction

endpackage

// File: rtl/antares_load_formatter.sv
// Load formatter: pulls the addressed byte/halfword out of a big-endian bus
// word and sign- or zero-extends it to 32 bits. Word loads pass through.
module antares_load_formatter
  import antares_mem_pkg::*;
(
  input  logic [31:0]  raw_data,
  input  logic [1:0]   offset,
  input  access_size_t size,
  input  logic         sign_extend,
  output logic [31:0]  load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed lane and extend it to a full word
  always_comb begin
    byte_lane = 8'h00;
    load_data = raw_data;
    case (offset)
      2'd0:    byte_lane = raw_data[31:24];
      2'd1:    byte_lane = raw_data[23:16];
      2'd2:    byte_lane = raw_data[15:8];
      default: byte_lane = raw_data[7:0];
    endcase
    half_lane = offset[1] ? raw_data[15:0] : raw_data[31:16];
    case (size)
      SIZE_BYTE: load_data = {{24{sign_extend & byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_data = {{16{sign_extend & half_lane[15]}}, half_lane};
      default:   load_data = raw_data;
    endcase
  end

endmodule

// File: rtl/antares_mem_access_unit.sv
// MEM-stage data-port initiator. Issues load/store transactions on a
// ready/enable port, stalls the pipeline until completion and reports
// misaligned accesses and bus errors. Optional macro ANTARES_MEM_TIMEOUT_EN
// adds a bus-wait timeout of TIMEOUT_CYCLES cycles that completes as a bus error.
module antares_mem_access_unit
  import antares_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic        mem_mem_byte,
  input  logic        mem_mem_halfword,
  input  logic        mem_mem_sign_extend,
  input  logic        mem_flush,
  input  logic        wb_stall,
  input  logic [31:0] dport_data_i,
  input  logic        dport_ready_i,
  input  logic        dport_error_i,
  output logic [31:0] dport_address_o,
  output logic [31:0] dport_data_o,
  output logic [3:0]  dport_sel_o,
  output logic        dport_wr_o,
  output logic        dport_enable_o,
  output logic [31:0] mem_read_data,
  output logic        mem_stall,
  output logic        exc_address_error,
  output logic        exc_bus_error
);

  mem_state_t   state, state_next;
  access_size_t req_size, size_q;
  logic [1:0]   offset_q;
  logic         sign_q;
  logic         flushed_q;
  logic [31:0]  rdata_q;
  logic         bus_err_q;
  logic         access, misaligned, req;
  logic         timeout, complete, bus_fault, flush_hit;
  logic [31:0]  store_lanes;
  logic [31:0]  formatted;

  // Decode access size, alignment and whether a bus request may be issued
  always_comb begin
    if (mem_mem_byte)          req_size = SIZE_BYTE;
    else if (mem_mem_halfword) req_size = SIZE_HALF;
    else                       req_size = SIZE_WORD;
    misaligned = ((req_size == SIZE_HALF) && mem_address[0]) ||
                 ((req_size == SIZE_WORD) && (mem_address[1:0] != 2'b00));
    access     = mem_mem_read | mem_mem_write;
    req        = access & ~mem_flush & ~misaligned;
  end

  // Replicate store data across every lane the size could occupy
  always_comb begin
    case (req_size)
      SIZE_BYTE: store_lanes = {4{mem_store_data[7:0]}};
      SIZE_HALF: store_lanes = {2{mem_store_data[15:0]}};
      default:   store_lanes = mem_store_data;
    endcase
  end

  antares_load_formatter u_formatter (
    .raw_data    (dport_data_i),
    .offset      (offset_q),
    .size        (size_q),
    .sign_extend (sign_q),
    .load_data   (formatted)
  );

`ifdef ANTARES_MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wait_cnt;

  // Count cycles spent waiting in BUSY; held at zero elsewhere so entry starts fresh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               wait_cnt <= '0;
    else if (state != BUSY) wait_cnt <= '0;
    else                    wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == BUSY) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign complete  = dport_ready_i | dport_error_i | timeout;
  assign bus_fault = dport_error_i | timeout;
  assign flush_hit = flushed_q | mem_flush;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and stall logic
  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          mem_stall  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (complete) state_next = flush_hit ? IDLE : DONE;
      end
      DONE: begin
        if (!wb_stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Port registers, captured load result and the one-cycle bus-error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dport_address_o <= '0;
      dport_data_o    <= '0;
      dport_sel_o     <= '0;
      dport_wr_o      <= 1'b0;
      dport_enable_o  <= 1'b0;
      size_q          <= SIZE_WORD;
      offset_q        <= 2'b00;
      sign_q          <= 1'b0;
      flushed_q       <= 1'b0;
      rdata_q         <= '0;
      bus_err_q       <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            dport_address_o <= {mem_address[31:2], 2'b00};
            dport_data_o    <= store_lanes;
            dport_sel_o     <= lane_select(req_size, mem_address[1:0]);
            dport_wr_o      <= mem_mem_write;
            dport_enable_o  <= 1'b1;
            size_q          <= req_size;
            offset_q        <= mem_address[1:0];
            sign_q          <= mem_mem_sign_extend;
            flushed_q       <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_flush) flushed_q <= 1'b1;
          if (complete) begin
            dport_enable_o <= 1'b0;
            rdata_q        <= (bus_fault | flush_hit | dport_wr_o) ? '0 : formatted;
            bus_err_q      <= bus_fault & ~flush_hit;
          end
        end
        DONE: begin
          if (!wb_stall) rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_read_data     = (state == DONE) ? rdata_q : '0;
  assign exc_bus_error     = bus_err_q;
  assign exc_address_error = access & misaligned & ~mem_flush & (state == IDLE);

endmodule

// File: tb/tb_antares_mem_access_unit.sv
// Testbench for antares_mem_access_unit: table-driven vectors, randomized
// transactions checked against an arithmetic reference model, and hand
// sequences for reset, flush and (with ANTARES_MEM_TIMEOUT_EN) timeout.
module tb_antares_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address, mem_store_data;
  logic        mem_mem_read, mem_mem_write, mem_mem_byte, mem_mem_halfword;
  logic        mem_mem_sign_extend, mem_flush, wb_stall;
  logic [31:0] dport_data_i;
  logic        dport_ready_i, dport_error_i;
  logic [31:0] dport_address_o, dport_data_o, mem_read_data;
  logic [3:0]  dport_sel_o;
  logic        dport_wr_o, dport_enable_o, mem_stall;
  logic        exc_address_error, exc_bus_error;

  int compared = 0;
  int mismatched = 0;

  antares_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_store_data(mem_store_data),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_byte(mem_mem_byte), .mem_mem_halfword(mem_mem_halfword),
    .mem_mem_sign_extend(mem_mem_sign_extend), .mem_flush(mem_flush),
    .wb_stall(wb_stall), .dport_data_i(dport_data_i),
    .dport_ready_i(dport_ready_i), .dport_error_i(dport_error_i),
    .dport_address_o(dport_address_o), .dport_data_o(dport_data_o),
    .dport_sel_o(dport_sel_o), .dport_wr_o(dport_wr_o),
    .dport_enable_o(dport_enable_o), .mem_read_data(mem_read_data),
    .mem_stall(mem_stall), .exc_address_error(exc_address_error),
    .exc_bus_error(exc_bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd, wr, byt, half, sext, flush;
    logic [31:0] bus_data;
    int          delay;
    logic        err;
    int          hold;
    logic        exp_addr_err;
    logic        exp_req;
    logic        exp_wr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_addr;
    logic [31:0] exp_dout;
    logic [31:0] exp_rdata;
  } vec_t;

  // Reference model: sizes in bytes, big-endian byte index = addr mod 4
  function automatic int m_bytes(logic byt, logic half);
    return byt ? 1 : (half ? 2 : 4);
  endfunction

  function automatic bit m_misaligned(logic [31:0] addr, int n);
    return (int'(addr % 4) % n) != 0;
  endfunction

  function automatic logic [3:0] m_sel(logic [31:0] addr, int n);
    int idx = int'(addr % 4);
    int lanes;
    if (n == 4) return 4'hF;
    lanes = (n == 2) ? 3 : 1;
    return 4'(lanes << (4 - n - idx));
  endfunction

  function automatic logic [31:0] m_store(logic [31:0] wdata, int n);
    longint unsigned v = longint'(wdata) % (64'd1 << (8 * n));
    longint unsigned r = 0;
    for (int k = 0; k < 4 / n; k++) r += v << (8 * n * k);
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] bus, logic [31:0] addr, int n, logic sext);
    int     idx = int'(addr % 4);
    longint v;
    if (n == 4) return bus;
    v = (longint'(bus) >> (8 * (4 - n - idx))) % (64'sd1 << (8 * n));
    if (sext && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
    return 32'(v);
  endfunction

  function automatic vec_t build(logic [31:0] addr, logic [31:0] wdata,
                                 logic rd, logic wr, logic byt, logic half, logic sext,
                                 logic flush, logic [31:0] bus, int delay, logic err, int hold,
                                 logic e_aerr, logic e_req, logic e_wr, logic [3:0] e_sel,
                                 logic [31:0] e_addr, logic [31:0] e_dout, logic [31:0] e_rdata);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr; v.byt = byt; v.half = half;
    v.sext = sext; v.flush = flush; v.bus_data = bus; v.delay = delay; v.err = err;
    v.hold = hold; v.exp_addr_err = e_aerr; v.exp_req = e_req; v.exp_wr = e_wr;
    v.exp_sel = e_sel; v.exp_addr = e_addr; v.exp_dout = e_dout; v.exp_rdata = e_rdata;
    return v;
  endfunction

  function automatic vec_t model_vec(logic [31:0] addr, logic [31:0] wdata,
                                     logic rd, logic wr, logic byt, logic half, logic sext,
                                     logic flush, logic [31:0] bus, int delay, logic err, int hold);
    int n = m_bytes(byt, half);
    bit mis = m_misaligned(addr, n);
    bit any = rd || wr;
    return build(addr, wdata, rd, wr, byt, half, sext, flush, bus, delay, err, hold,
                 any && mis && !flush, any && !mis && !flush, wr, m_sel(addr, n),
                 addr - (addr % 4), m_store(wdata, n),
                 err ? 32'h0 : m_load(bus, addr, n, sext));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idle_inputs();
    mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_flush = 1'b0;
    dport_ready_i = 1'b0; dport_error_i = 1'b0; wb_stall = 1'b0;
  endtask

  // Run one complete transaction on a fixed cycle schedule and check every cycle
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    mem_address = v.addr; mem_store_data = v.wdata;
    mem_mem_read = v.rd; mem_mem_write = v.wr; mem_mem_byte = v.byt;
    mem_mem_halfword = v.half; mem_mem_sign_extend = v.sext; mem_flush = v.flush;
    dport_ready_i = 1'b0; dport_error_i = 1'b0; wb_stall = 1'b0;
    #1;
    checkOutput("addr_err", exc_address_error, v.exp_addr_err);
    checkOutput("issue_stall", mem_stall, v.exp_req);
    checkOutput("idle_enable", dport_enable_o, 0);
    if (!v.exp_req) begin
      @(negedge clk);
      idle_inputs();
      #1;
      checkOutput("no_issue_enable", dport_enable_o, 0);
      checkOutput("no_issue_stall", mem_stall, 0);
      return;
    end
    for (int b = 1; b <= v.delay; b++) begin
      @(negedge clk);
      dport_data_i  = v.bus_data;
      dport_ready_i = (b == v.delay);
      dport_error_i = v.err && (b == v.delay);
      #1;
      checkOutput("busy_enable", dport_enable_o, 1);
      checkOutput("busy_stall", mem_stall, 1);
      if (b == 1) begin
        checkOutput("sel", dport_sel_o, v.exp_sel);
        checkOutput("address", dport_address_o, v.exp_addr);
        checkOutput("store_data", dport_data_o, v.exp_dout);
        checkOutput("wr", dport_wr_o, v.exp_wr);
      end
    end
    @(negedge clk);
    dport_ready_i = 1'b0; dport_error_i = 1'b0; dport_data_i = $urandom;
    mem_mem_read = 1'b0; mem_mem_write = 1'b0;
    wb_stall = (v.hold > 0);
    #1;
    checkOutput("done_enable", dport_enable_o, 0);
    checkOutput("done_stall", mem_stall, 0);
    checkOutput("done_bus_err", exc_bus_error, v.err);
    if (!v.wr) checkOutput("done_rdata", mem_read_data, v.exp_rdata);
    for (int k = 1; k <= v.hold; k++) begin
      @(negedge clk);
      wb_stall = (k < v.hold);
      #1;
      checkOutput("hold_stall", mem_stall, 0);
      checkOutput("hold_bus_err", exc_bus_error, 0);
      if (!v.wr) checkOutput("hold_rdata", mem_read_data, v.exp_rdata);
    end
    @(negedge clk);
    wb_stall = 1'b0;
    #1;
    checkOutput("after_rdata", mem_read_data, 0);
    checkOutput("after_stall", mem_stall, 0);
    checkOutput("after_bus_err", exc_bus_error, 0);
  endtask

  vec_t table_vecs[14];

  initial begin
    rst = 1'b0;
    mem_address = '0; mem_store_data = '0; mem_mem_byte = 1'b0;
    mem_mem_halfword = 1'b0; mem_mem_sign_extend = 1'b0; dport_data_i = '0;
    idle_inputs();

    table_vecs[0]  = build(32'h100, 32'h0, 1,0,0,0,0,0, 32'hDEADBEEF, 2,0,0, 0,1,0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF);
    table_vecs[1]  = build(32'h103, 32'h0, 1,0,1,0,1,0, 32'h123456F0, 1,0,0, 0,1,0, 4'h1, 32'h100, 32'h0, 32'hFFFFFFF0);
    table_vecs[2]  = build(32'h103, 32'h0, 1,0,1,0,0,0, 32'h123456F0, 1,0,0, 0,1,0, 4'h1, 32'h100, 32'h0, 32'h000000F0);
    table_vecs[3]  = build(32'h202, 32'h0000ABCD, 0,1,0,1,0,0, 32'h0, 1,0,0, 0,1,1, 4'h3, 32'h200, 32'hABCDABCD, 32'h0);
    table_vecs[4]  = build(32'h101, 32'h0, 1,0,0,0,0,0, 32'h0, 1,0,0, 1,0,0, 4'hF, 32'h100, 32'h0, 32'h0);
    table_vecs[5]  = build(32'h300, 32'h0, 1,0,0,0,0,0, 32'h55555555, 1,1,3, 0,1,0, 4'hF, 32'h300, 32'h0, 32'h0);
    table_vecs[6]  = build(32'h102, 32'h0, 1,0,0,1,1,0, 32'h12348001, 3,0,1, 0,1,0, 4'h3, 32'h100, 32'h0, 32'hFFFF8001);
    table_vecs[7]  = build(32'h100, 32'h0, 1,0,0,1,0,0, 32'h80011234, 1,0,0, 0,1,0, 4'hC, 32'h100, 32'h0, 32'h00008001);
    table_vecs[8]  = build(32'h201, 32'h0000005A, 0,1,1,0,0,0, 32'h0, 2,0,0, 0,1,1, 4'h4, 32'h200, 32'h5A5A5A5A, 32'h0);
    table_vecs[9]  = build(32'h103, 32'h0, 1,0,0,1,0,0, 32'h0, 1,0,0, 1,0,0, 4'h3, 32'h100, 32'h0, 32'h0);
    table_vecs[10] = build(32'h100, 32'h0, 1,0,0,0,0,1, 32'h0, 1,0,0, 0,0,0, 4'hF, 32'h100, 32'h0, 32'h0);
    table_vecs[11] = build(32'h400, 32'h12345678, 1,1,0,0,0,0, 32'h0, 1,0,0, 0,1,1, 4'hF, 32'h400, 32'h12345678, 32'h0);
    table_vecs[12] = build(32'h102, 32'h0, 1,0,1,0,1,0, 32'h00007F00, 1,0,2, 0,1,0, 4'h2, 32'h100, 32'h0, 32'h0000007F);
    table_vecs[13] = build(32'h101, 32'h0, 1,0,0,0,0,1, 32'h0, 1,0,0, 0,0,0, 4'hF, 32'h100, 32'h0, 32'h0);

    // Reset state
    #3;
    checkOutput("rst_enable", dport_enable_o, 0);
    checkOutput("rst_address", dport_address_o, 0);
    checkOutput("rst_data", dport_data_o, 0);
    checkOutput("rst_sel", dport_sel_o, 0);
    checkOutput("rst_wr", dport_wr_o, 0);
    checkOutput("rst_rdata", mem_read_data, 0);
    checkOutput("rst_bus_err", exc_bus_error, 0);
    checkOutput("rst_stall", mem_stall, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) applyStimulus(table_vecs[i]);

    // Randomized transactions against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] addr;
      int kind;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      kind = $urandom_range(0, 2);
      applyStimulus(model_vec(addr, $urandom,
                              kind != 1, kind != 0,
                              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                              $urandom, $urandom_range(1, 4),
                              1'($urandom_range(0, 7) == 0), $urandom_range(0, 2)));
    end

    // Flush during BUSY: transaction completes on the bus, no DONE, no bus error
    @(negedge clk);
    mem_address = 32'h700; mem_mem_read = 1'b1; mem_mem_byte = 1'b0; mem_mem_halfword = 1'b0;
    #1;
    checkOutput("flush_issue_stall", mem_stall, 1);
    @(negedge clk);
    mem_flush = 1'b1; mem_mem_read = 1'b0;
    #1;
    checkOutput("flush_busy_enable", dport_enable_o, 1);
    @(negedge clk);
    mem_flush = 1'b0; dport_ready_i = 1'b1; dport_error_i = 1'b1; dport_data_i = 32'hCAFEF00D;
    #1;
    checkOutput("flush_busy2_enable", dport_enable_o, 1);
    @(negedge clk);
    dport_ready_i = 1'b0; dport_error_i = 1'b0;
    #1;
    checkOutput("flush_end_enable", dport_enable_o, 0);
    checkOutput("flush_end_bus_err", exc_bus_error, 0);
    checkOutput("flush_end_rdata", mem_read_data, 0);
    checkOutput("flush_end_stall", mem_stall, 0);

    // Reset in the middle of BUSY, then a stray ready afterwards
    @(negedge clk);
    mem_address = 32'h600; mem_mem_read = 1'b1;
    #1;
    @(negedge clk);
    #1;
    checkOutput("rstmid_busy_enable", dport_enable_o, 1);
    #2;
    rst = 1'b0; mem_mem_read = 1'b0;
    #1;
    checkOutput("rstmid_enable", dport_enable_o, 0);
    checkOutput("rstmid_stall", mem_stall, 0);
    @(negedge clk);
    rst = 1'b1; dport_ready_i = 1'b1; dport_data_i = 32'hFFFFFFFF;
    #1;
    checkOutput("stray_enable", dport_enable_o, 0);
    checkOutput("stray_stall", mem_stall, 0);
    @(negedge clk);
    dport_ready_i = 1'b0;
    #1;
    checkOutput("stray_rdata", mem_read_data, 0);
    checkOutput("stray_bus_err", exc_bus_error, 0);
    checkOutput("stray_enable2", dport_enable_o, 0);

`ifdef ANTARES_MEM_TIMEOUT_EN
    // No ready ever arrives: four BUSY cycles, then a forced bus error
    @(negedge clk);
    mem_address = 32'h500; mem_mem_read = 1'b1;
    #1;
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      #1;
      checkOutput("to_busy_enable", dport_enable_o, 1);
      checkOutput("to_busy_stall", mem_stall, 1);
    end
    @(negedge clk);
    mem_mem_read = 1'b0;
    #1;
    checkOutput("to_done_enable", dport_enable_o, 0);
    checkOutput("to_done_bus_err", exc_bus_error, 1);
    checkOutput("to_done_rdata", mem_read_data, 0);
    checkOutput("to_done_stall", mem_stall, 0);
    @(negedge clk);
    #1;
    checkOutput("to_after_bus_err", exc_bus_error, 0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
